// File: rtl/calendar_pkg.sv
// Shared field widths, range limits and the packed time/date record for the
// calendar clock. Also provides the Gregorian leap-year test used wherever a
// month length is needed.
package calendar_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 14;

    localparam logic [SEC_W-1:0]   MAX_SEC    = SEC_W'(59);
    localparam logic [MIN_W-1:0]   MAX_MIN    = MIN_W'(59);
    localparam logic [HOUR_W-1:0]  MAX_HOUR   = HOUR_W'(23);
    localparam logic [HOUR_W-1:0]  NOON_HOUR  = HOUR_W'(12);
    localparam logic [MONTH_W-1:0] MAX_MONTH  = MONTH_W'(12);
    localparam logic [DAY_W-1:0]   FIRST_DAY  = DAY_W'(1);
    localparam logic [MONTH_W-1:0] FIRST_MON  = MONTH_W'(1);

    // Complete time-of-day and calendar date, most significant field first.
    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   min;
        logic [SEC_W-1:0]   sec;
    } cal_t;

    // Full Gregorian rule; year 0 counts as divisible by 400 and is leap.
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        logic div4;
        logic div100;
        logic div400;
        div4   = (year[1:0] == 2'b00);
        div100 = ((year % YEAR_W'(100)) == '0);
        div400 = ((year % YEAR_W'(400)) == '0);
        return (div4 && !div100) || div400;
    endfunction

endpackage

// File: rtl/month_len.sv
// Number of days in a given month of a given year, purely combinational.
// Ports:
//   month  - month number 1..12 (other codes yield 31; callers range-check)
//   year   - full binary year, used only for the February leap adjustment
//   days_c - days in that month (28..31)
module month_len
    import calendar_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   days_c
);

    // Lookup by month with February resolved through the leap rule.
    always_comb begin
        days_c = DAY_W'(31);
        case (month)
            MONTH_W'(2):  days_c = is_leap(year) ? DAY_W'(29) : DAY_W'(28);
            MONTH_W'(4),
            MONTH_W'(6),
            MONTH_W'(9),
            MONTH_W'(11): days_c = DAY_W'(30);
            default:      days_c = DAY_W'(31);
        endcase
    end

endmodule

// File: rtl/calendar_clock.sv
// Real-time calendar clock: a prescaler turns CLK_DIV clock cycles into one
// second, and a single-edge carry chain rolls seconds through to years. A
// whole-date load can replace the state when every field is in range.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   run                 - enables the prescaler (time frozen when low)
//   mode                - display format for hour_disp (0: 24h, 1: 12h)
//   load, load_*        - single-cycle request to set the full time/date
//   sec..year           - registered current time/date, binary
//   hour_disp, pm       - display hour and afternoon flag, derived from hour
//   sec_tick            - one-cycle pulse after each second advance
//   load_err            - one-cycle pulse after a rejected load
module calendar_clock
    import calendar_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50_000_000,
    parameter int unsigned RESET_YEAR = 2024,
    parameter int unsigned YEAR_MAX   = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               mode,
    input  logic               load,
    input  logic [SEC_W-1:0]   load_sec,
    input  logic [MIN_W-1:0]   load_min,
    input  logic [HOUR_W-1:0]  load_hour,
    input  logic [DAY_W-1:0]   load_day,
    input  logic [MONTH_W-1:0] load_month,
    input  logic [YEAR_W-1:0]  load_year,
    output logic [SEC_W-1:0]   sec,
    output logic [MIN_W-1:0]   min,
    output logic [HOUR_W-1:0]  hour,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic [HOUR_W-1:0]  hour_disp,
    output logic               pm,
    output logic               sec_tick,
    output logic               load_err
);

    localparam int unsigned PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] YEAR_RST  = YEAR_W'(RESET_YEAR);

    localparam cal_t RESET_VAL = '{
        year:  YEAR_RST,
        month: FIRST_MON,
        day:   FIRST_DAY,
        hour:  '0,
        min:   '0,
        sec:   '0
    };

    cal_t             cur_q, cur_d;
    cal_t             cur_inc;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             sec_tick_q, sec_tick_d;
    logic             load_err_q, load_err_d;

    logic [DAY_W-1:0] cur_days;
    logic [DAY_W-1:0] load_days;
    logic             advance;
    logic             load_ok;
    cal_t             load_val;

    // Length of the current month drives the day->month carry.
    month_len u_cur_len (
        .month  (cur_q.month),
        .year   (cur_q.year),
        .days_c (cur_days)
    );

    // Length of the requested month bounds the requested day.
    month_len u_load_len (
        .month  (load_month),
        .year   (load_year),
        .days_c (load_days)
    );

    assign advance = run && (pre_q == PRE_LAST);

    // Every field of a load must be in range for it to be taken at all.
    always_comb begin
        load_ok = (load_sec   <= MAX_SEC)
               && (load_min   <= MAX_MIN)
               && (load_hour  <= MAX_HOUR)
               && (load_month >= FIRST_MON) && (load_month <= MAX_MONTH)
               && (load_year  <= YEAR_LAST)
               && (load_day   >= FIRST_DAY) && (load_day <= load_days);
    end

    always_comb begin
        load_val = '{
            year:  load_year,
            month: load_month,
            day:   load_day,
            hour:  load_hour,
            min:   load_min,
            sec:   load_sec
        };
    end

    // Current time plus one second, with the full carry resolved at once.
    always_comb begin
        cur_inc = cur_q;
        if (cur_q.sec >= MAX_SEC) begin
            cur_inc.sec = '0;
            if (cur_q.min >= MAX_MIN) begin
                cur_inc.min = '0;
                if (cur_q.hour >= MAX_HOUR) begin
                    cur_inc.hour = '0;
                    if (cur_q.day >= cur_days) begin
                        cur_inc.day = FIRST_DAY;
                        if (cur_q.month >= MAX_MONTH) begin
                            cur_inc.month = FIRST_MON;
                            cur_inc.year  = (cur_q.year >= YEAR_LAST)
                                          ? '0
                                          : cur_q.year + YEAR_W'(1);
                        end else begin
                            cur_inc.month = cur_q.month + MONTH_W'(1);
                        end
                    end else begin
                        cur_inc.day = cur_q.day + DAY_W'(1);
                    end
                end else begin
                    cur_inc.hour = cur_q.hour + HOUR_W'(1);
                end
            end else begin
                cur_inc.min = cur_q.min + MIN_W'(1);
            end
        end else begin
            cur_inc.sec = cur_q.sec + SEC_W'(1);
        end
    end

    // Next state: an accepted load overrides (and swallows) any advance; a
    // rejected load only raises the error pulse and lets time run on.
    always_comb begin
        cur_d      = cur_q;
        pre_d      = pre_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        if (load && load_ok) begin
            cur_d = load_val;
            pre_d = '0;
        end else begin
            load_err_d = load;
            if (run) begin
                pre_d = advance ? '0 : pre_q + PRE_W'(1);
            end
            if (advance) begin
                cur_d      = cur_inc;
                sec_tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q      <= RESET_VAL;
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            pre_q      <= pre_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    // 12-hour view: midnight shows 12, afternoon hours fold down by 12.
    always_comb begin
        hour_disp = cur_q.hour;
        if (mode) begin
            if (cur_q.hour == '0) begin
                hour_disp = NOON_HOUR;
            end else if (cur_q.hour > NOON_HOUR) begin
                hour_disp = cur_q.hour - NOON_HOUR;
            end
        end
    end

    assign pm       = (cur_q.hour >= NOON_HOUR);
    assign sec      = cur_q.sec;
    assign min      = cur_q.min;
    assign hour     = cur_q.hour;
    assign day      = cur_q.day;
    assign month    = cur_q.month;
    assign year     = cur_q.year;
    assign sec_tick = sec_tick_q;
    assign load_err = load_err_q;

endmodule

// File: doc/calendar_clock.md
CALENDAR_CLOCK -- requirements
Module: calendar_clock

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000, clk cycles per second (>=2).
REQ-002 Parameter RESET_YEAR, default 2024, year loaded at reset (0..YEAR_MAX).
REQ-003 Parameter YEAR_MAX, default 9999, last year before wrap to 0 (<=16383).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 run  in  1  1 = prescaler advances; 0 = time frozen, prescaler held.
REQ-007 mode  in  1  0 = 24-hour display, 1 = 12-hour display; affects hour_disp/pm only.
REQ-008 load  in  1  single-cycle request to load all load_* fields.
REQ-009 load_sec/load_min  in  6 each  requested seconds/minutes, binary.
REQ-010 load_hour  in  5  requested hour 0..23, binary, always 24-hour.
REQ-011 load_day  in  5; load_month  in  4; load_year  in  14  requested date, binary.
REQ-012 sec/min  out  6 each; hour  out  5 (0..23); day  out  5; month  out  4; year  out  14  current time/date, binary, registered.
REQ-013 hour_disp  out  5  display hour: equals hour when mode=0, 1..12 when mode=1.
REQ-014 pm  out  1  1 when hour>=12, regardless of mode.
REQ-015 sec_tick  out  1  one-cycle pulse per second advance.
REQ-016 load_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 while run=1; on the edge where it equals CLK_DIV-1 it SHALL return to 0 and advance time by one second.
REQ-018 sec_tick SHALL be 1 in exactly the cycle following a second advance, 0 otherwise.
REQ-019 Carry chain, resolved in one edge: sec 59->0 carries min; min 59->0 carries hour; hour 23->0 carries day; day==days_in_month->1 carries month; month 12->1 carries year; year YEAR_MAX->0.
REQ-020 days_in_month SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for month 2 in a leap year, otherwise 28.
REQ-021 Leap year SHALL be full Gregorian: divisible by 4 and not by 100, or divisible by 400; year 0 is leap.
REQ-022 Load SHALL be accepted only if sec<=59, min<=59, hour<=23, 1<=month<=12, year<=YEAR_MAX, 1<=day<=days_in_month(load_month, load_year).
REQ-023 Accepted load: all fields take load_* values on the next edge, prescaler cleared to 0, no sec_tick that cycle.
REQ-024 Rejected load: no state changes, load_err=1 in the following cycle; a pending second advance that cycle proceeds normally.
REQ-025 Load and a second advance in the same cycle: accepted load wins, the advance is discarded.
REQ-026 run=0: no advance, prescaler held; loads still honoured.
REQ-027 hour_disp in mode=1: hour 0 -> 12, 1..12 -> hour, 13..23 -> hour-12; combinational from registered hour and mode.

Reset
REQ-028 rst=1 at an edge SHALL set sec=0, min=0, hour=0, day=1, month=1, year=RESET_YEAR, prescaler=0, sec_tick=0, load_err=0; overrides load and run.
REQ-029 Reset asserted mid-second SHALL discard prescaler progress; first advance occurs CLK_DIV cycles after the first edge with rst=0 and run=1.

Structure
REQ-030 Package calendar_pkg SHALL hold field widths, MAX_SEC/MAX_MIN/MAX_HOUR constants, and a packed time/date struct type.
REQ-031 Sub-module month_len SHALL compute days_in_month(month, year) combinationally; instantiated twice (current date, load validation).
REQ-032 BCD/7-segment conversion is out of scope; downstream display logic consumes the binary outputs.

Verification (CLK_DIV=4 unless stated)
REQ-033 Reset, run=1 for 8 cycles -> sec=2, sec_tick pulsed at cycles 5 and 9 after reset release.
REQ-034 Load 23:59:59 28/02/2024, one second -> 00:00:00 29/02/2024; same from 28/02/2100 -> 01/03/2100; from 28/02/2000 -> 29/02/2000.
REQ-035 Load 23:59:59 31/12/9999, one second -> 00:00:00 01/01/0000, sec_tick=1.
REQ-036 Load day=31 month=4, and day=29 month=2 year=2023 -> load_err pulse each, all fields unchanged.
REQ-037 mode=1 with hour=0, 12, 13 -> hour_disp=12/pm=0, 12/pm=1, 1/pm=1; mode=0 with hour=13 -> hour_disp=13.
REQ-038 Valid load coincident with prescaler=3, and rst=1 coincident with load -> load values without advance; reset values respectively.
